// File: rtl/id_issue_stage.sv
// Decode/issue stage: valid/ready from fetch, registered operand packet to execute.
// Define ID_SCOREBOARD_EN to add the pending-write scoreboard that stalls RAW/WAW hazards.
module id_issue_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        id_ready,
  output logic [4:0]  rf_r1_addr,
  output logic [4:0]  rf_r2_addr,
  input  logic [31:0] rf_r1_dout,
  input  logic [31:0] rf_r2_dout,
  input  logic        wb_wr,
  input  logic [4:0]  wb_addr,
  input  logic        flush,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs_val,
  output logic [31:0] ex_rt_val,
  output logic [31:0] ex_imm,
  output logic [5:0]  ex_op,
  output logic [5:0]  ex_funct,
  output logic [4:0]  ex_dst,
  output logic        ex_wr
);

  logic        d_valid;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic        acc;
  logic        d_fire;
  logic        hazard;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  dst;
  logic        wr;
  logic [31:0] imm;

  assign op    = d_instr[31:26];
  assign rs    = d_instr[25:21];
  assign rt    = d_instr[20:16];
  assign rd    = d_instr[15:11];
  assign funct = d_instr[5:0];

  assign d_fire   = d_valid & ~hazard & (~ex_valid | ex_ready);
  assign id_ready = ~d_valid | d_fire;
  assign acc      = if_valid & id_ready;

  // A held instruction keeps presenting its own sources so write-through data stays fresh.
  assign rf_r1_addr = acc ? if_instr[25:21] : rs;
  assign rf_r2_addr = acc ? if_instr[20:16] : rt;

  always_comb begin
    dst = 5'd0;
    wr  = 1'b0;
    if (op == 6'h00) begin
      dst = rd;
      wr  = (funct != 6'h08);
    end else if (op == 6'h03) begin
      dst = 5'd31;
      wr  = 1'b1;
    end else if ((op >= 6'h08 && op <= 6'h0F) || (op >= 6'h20 && op <= 6'h25)) begin
      dst = rt;
      wr  = 1'b1;
    end
    if (dst == 5'd0) wr = 1'b0;
  end

  assign imm = (op == 6'h0C || op == 6'h0D || op == 6'h0E) ? {16'h0000, d_instr[15:0]}
                                                          : {{16{d_instr[15]}}, d_instr[15:0]};

`ifdef ID_SCOREBOARD_EN
  logic [31:0] busy;
  logic [31:0] busy_nxt;
  logic        rs_used;
  logic        rt_used;
  logic        rs_haz;
  logic        rt_haz;

  assign rs_used = ~(op == 6'h02 || op == 6'h03 || op == 6'h0F) && (rs != 5'd0);
  assign rt_used = (op == 6'h00 || op == 6'h04 || op == 6'h05 ||
                    op == 6'h28 || op == 6'h29 || op == 6'h2B) && (rt != 5'd0);

  // A writeback landing this cycle is already forwarded by the register file.
  assign rs_haz = rs_used & busy[rs] & ~(wb_wr & (wb_addr == rs));
  assign rt_haz = rt_used & busy[rt] & ~(wb_wr & (wb_addr == rt));
  assign hazard = rs_haz | rt_haz | (wr & busy[dst]);

  always_comb begin
    busy_nxt = busy;
    if (wb_wr) busy_nxt[wb_addr] = 1'b0;
    if (flush & ex_valid & ex_wr & ~ex_ready) busy_nxt[ex_dst] = 1'b0;
    if (d_fire & wr & ~flush) busy_nxt[dst] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= 32'h0;
    else        busy <= busy_nxt;
  end
`else
  logic unused_wb;
  assign hazard    = 1'b0;
  assign unused_wb = ^{wb_wr, wb_addr};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_valid <= 1'b0;
      d_instr <= 32'h0;
      d_pc    <= 32'h0;
    end else if (flush) begin
      d_valid <= 1'b0;
    end else if (acc) begin
      d_valid <= 1'b1;
      d_instr <= if_instr;
      d_pc    <= if_pc;
    end else if (d_fire) begin
      d_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid  <= 1'b0;
      ex_pc     <= 32'h0;
      ex_rs_val <= 32'h0;
      ex_rt_val <= 32'h0;
      ex_imm    <= 32'h0;
      ex_op     <= 6'h0;
      ex_funct  <= 6'h0;
      ex_dst    <= 5'h0;
      ex_wr     <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (d_fire) begin
      ex_valid  <= 1'b1;
      ex_pc     <= d_pc;
      ex_rs_val <= rf_r1_dout;
      ex_rt_val <= rf_r2_dout;
      ex_imm    <= imm;
      ex_op     <= op;
      ex_funct  <= funct;
      ex_dst    <= dst;
      ex_wr     <= wr;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_issue_stage.sv
// Scoreboard bench for id_issue_stage with a write-through register file model.
module tb_id_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic [4:0]  rf_r1_addr;
  logic [4:0]  rf_r2_addr;
  logic [31:0] rf_r1_dout;
  logic [31:0] rf_r2_dout;
  logic        wb_wr;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs_val;
  logic [31:0] ex_rt_val;
  logic [31:0] ex_imm;
  logic [5:0]  ex_op;
  logic [5:0]  ex_funct;
  logic [4:0]  ex_dst;
  logic        ex_wr;

  id_issue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
    .rf_r1_addr(rf_r1_addr), .rf_r2_addr(rf_r2_addr),
    .rf_r1_dout(rf_r1_dout), .rf_r2_dout(rf_r2_dout),
    .wb_wr(wb_wr), .wb_addr(wb_addr), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_imm(ex_imm),
    .ex_op(ex_op), .ex_funct(ex_funct), .ex_dst(ex_dst), .ex_wr(ex_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: address registered, read data forwards a same-cycle write.
  logic [31:0] regs [32];
  logic [4:0]  a1_q;
  logic [4:0]  a2_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? 32'h0 : 32'h100 + i;
      a1_q <= 5'd0;
      a2_q <= 5'd0;
    end else begin
      if (wb_wr && wb_addr != 5'd0) regs[wb_addr] <= wb_data;
      a1_q <= rf_r1_addr;
      a2_q <= rf_r2_addr;
    end
  end
  assign rf_r1_dout = (wb_wr && wb_addr == a1_q && a1_q != 5'd0) ? wb_data : regs[a1_q];
  assign rf_r2_dout = (wb_wr && wb_addr == a2_q && a2_q != 5'd0) ? wb_data : regs[a2_q];

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [4:0]  dst;
    logic        wr;
  } pkt_t;

  pkt_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ex_valid && ex_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_packet_pc", ex_pc, 32'hFFFF_FFFF);
      end else begin
        pkt_t p;
        p = exp_q.pop_front();
        check("pkt_pc", ex_pc, p.pc);
        check("pkt_rs_val", ex_rs_val, p.rs);
        check("pkt_rt_val", ex_rt_val, p.rt);
        check("pkt_imm", ex_imm, p.imm);
        check("pkt_op", {26'b0, ex_op}, {26'b0, p.instr[31:26]});
        check("pkt_funct", {26'b0, ex_funct}, {26'b0, p.instr[5:0]});
        check("pkt_wr", {31'b0, ex_wr}, {31'b0, p.wr});
        if (p.wr) check("pkt_dst", {27'b0, ex_dst}, {27'b0, p.dst});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] rsv,
                      input logic [31:0] rtv, input logic [31:0] imm, input logic [4:0] dst,
                      input logic wr);
    pkt_t p;
    bit   ok;
    int   n;
    p.instr = instr; p.pc = pc; p.rs = rsv; p.rt = rtv; p.imm = imm; p.dst = dst; p.wr = wr;
    exp_q.push_back(p);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
    n = 0;
    do begin
      @(negedge clk);
      ok = id_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) check("send_accept_timeout", 32'd0, 32'd1);
    if_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_wr = 1'b1; wb_addr = a; wb_data = d;
    step();
    wb_wr = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_instr = 32'h0; if_pc = 32'h0;
    wb_wr = 1'b0; wb_addr = 5'd0; wb_data = 32'h0; flush = 1'b0; ex_ready = 1'b1;
    step(); step();
    @(negedge clk);
    check("rst_id_ready", {31'b0, id_ready}, 32'd1);
    check("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
    check("rst_r1_addr", {27'b0, rf_r1_addr}, 32'd0);
    check("rst_r2_addr", {27'b0, rf_r2_addr}, 32'd0);
    check("rst_ex_pc", ex_pc, 32'd0);
    check("rst_ex_imm", ex_imm, 32'd0);
    check("rst_ex_wr", {31'b0, ex_wr}, 32'd0);
    rst_n = 1'b1;
    step();

    // addi $8,$0,5: one cycle in D
    send(32'h20080005, 32'h100, 32'h0, 32'h108, 32'h5, 5'd8, 1'b1);
    @(negedge clk); check("addi_lat_in_d", {31'b0, ex_valid}, 32'd0);
    step();
    @(negedge clk); check("addi_lat_ex", {31'b0, ex_valid}, 32'd1);
    step();

    // add $9,$8,$8 stalls on busy $8 until writeback supplies 5
`ifdef ID_SCOREBOARD_EN
    send(32'h01084820, 32'h104, 32'h5, 32'h5, 32'h4820, 5'd9, 1'b1);
`else
    send(32'h01084820, 32'h104, 32'h108, 32'h108, 32'h4820, 5'd9, 1'b1);
`endif
    @(negedge clk);
`ifdef ID_SCOREBOARD_EN
    check("raw_stall_ready_0", {31'b0, id_ready}, 32'd0);
`endif
    step();
    @(negedge clk);
`ifdef ID_SCOREBOARD_EN
    check("raw_stall_ready_1", {31'b0, id_ready}, 32'd0);
    check("raw_stall_no_ex", {31'b0, ex_valid}, 32'd0);
`endif
    step();
    wb_wr = 1'b1; wb_addr = 5'd8; wb_data = 32'h5;
    @(negedge clk);
`ifdef ID_SCOREBOARD_EN
    check("raw_release_ready", {31'b0, id_ready}, 32'd1);
`endif
    step();
    wb_wr = 1'b0;
    drain();
    wb(5'd9, 32'd10);

    // ori zero-extends, addi sign-extends; addi $2 waits on WAW with the ori
    send(32'h3402FFFF, 32'h200, 32'h0, 32'h102, 32'h0000FFFF, 5'd2, 1'b1);
    send(32'h2002FFFF, 32'h204, 32'h0, 32'h7, 32'hFFFFFFFF, 5'd2, 1'b1);
    wb_wr = 1'b1; wb_addr = 5'd2; wb_data = 32'h7;
    @(negedge clk);
`ifdef ID_SCOREBOARD_EN
    check("waw_stall_ready", {31'b0, id_ready}, 32'd0);
`endif
    step();
    wb_wr = 1'b0;
    drain();
    wb(5'd2, 32'h3);

    // three cycles of EX backpressure with a stream of independent addis
    ex_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++)
          send(32'h200A0001 + (k << 16) + k, 32'h300 + 4 * k, 32'h0, 32'h10A + k,
               32'h1 + k, 5'(10 + k), 1'b1);
      end
      begin
        step(); step(); step();
        ex_ready = 1'b1;
      end
    join
    drain();

    // flush an unconsumed lw $5, then add $6,$5,$5 must issue without stall
    ex_ready = 1'b0;
    send(32'h8C050000, 32'h400, 32'h0, 32'h105, 32'h0, 5'd5, 1'b1);
    step();
    @(negedge clk); check("lw_held_in_ex", {31'b0, ex_valid}, 32'd1);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk); check("flush_ex_valid", {31'b0, ex_valid}, 32'd0);
    step();
    ex_ready = 1'b1;
    send(32'h00A53020, 32'h404, 32'h105, 32'h105, 32'h3020, 5'd6, 1'b1);
    @(negedge clk); check("post_flush_in_d", {31'b0, ex_valid}, 32'd0);
    step();
    @(negedge clk); check("post_flush_no_stall", {31'b0, ex_valid}, 32'd1);
    step();
    drain();

    // write to $0, jal link, then sw reading a busy rt
    send(32'h20000001, 32'h500, 32'h0, 32'h0, 32'h1, 5'd0, 1'b0);
    send(32'h0C000010, 32'h504, 32'h0, 32'h0, 32'h10, 5'd31, 1'b1);
    send(32'h8C070000, 32'h508, 32'h0, 32'h107, 32'h0, 5'd7, 1'b1);
`ifdef ID_SCOREBOARD_EN
    send(32'hAC070004, 32'h50C, 32'h0, 32'h77, 32'h4, 5'd7, 1'b0);
`else
    send(32'hAC070004, 32'h50C, 32'h0, 32'h107, 32'h4, 5'd7, 1'b0);
`endif
    @(negedge clk);
`ifdef ID_SCOREBOARD_EN
    check("sw_stall_ready_0", {31'b0, id_ready}, 32'd0);
`endif
    step();
    @(negedge clk);
`ifdef ID_SCOREBOARD_EN
    check("sw_stall_ready_1", {31'b0, id_ready}, 32'd0);
`endif
    step();
    wb_wr = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
    @(negedge clk);
`ifdef ID_SCOREBOARD_EN
    check("sw_release_ready", {31'b0, id_ready}, 32'd1);
`endif
    step();
    wb_wr = 1'b0;
    drain();

    // reset while an instruction sits in D
    send(32'h200E0001, 32'h600, 32'h0, 32'h10E, 32'h1, 5'd14, 1'b1);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_ex_valid", {31'b0, ex_valid}, 32'd0);
    check("midrst_id_ready", {31'b0, id_ready}, 32'd1);
    check("midrst_r1_addr", {27'b0, rf_r1_addr}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    @(negedge clk); check("post_rst_no_packet", {31'b0, ex_valid}, 32'd0);
    step();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
